// File: rtl/start_srl_fifo.sv
// Shift-register FIFO with first-word fall-through read and registered empty/full flags.
// Storage shifts toward higher indices on a push; the oldest entry sits at entry[cnt-1].
module start_srl_fifo #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n
);

    localparam int              CNT_W   = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_next;
    logic                  r_empty_n;
    logic                  r_full_n;
    logic                  w_push;
    logic                  w_pop;
    logic [ADDR_WIDTH-1:0] w_raddr;

    // The registered flags gate the requests, so a push into a full FIFO or a pop from an
    // empty one is simply never accepted.
    assign w_push = if_write_ce & if_write & r_full_n;
    assign w_pop  = if_read_ce  & if_read  & r_empty_n;

    always_comb begin
        // NOTE: assigning the default first means every path writes w_cnt_next, so no latch is inferred.
        w_cnt_next = r_cnt;
        if (w_push && !w_pop) begin
            w_cnt_next = r_cnt + 1'b1;
        end else if (!w_push && w_pop) begin
            w_cnt_next = r_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: non-blocking assignments let all state registers update together at the edge.
            r_cnt     <= '0;
            r_empty_n <= 1'b0;
            r_full_n  <= 1'b1;
        end else begin
            r_cnt     <= w_cnt_next;
            r_empty_n <= (w_cnt_next != '0);
            r_full_n  <= (w_cnt_next != C_DEPTH);
        end
    end

    // NOTE: storage has no reset; clearing cnt is enough to discard its contents.
    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        if (g == 0) begin : g_head
            always_ff @(posedge clk) begin
                if (w_push) begin
                    r_mem[0] <= if_din;
                end
            end
        end else begin : g_tail
            always_ff @(posedge clk) begin
                if (w_push) begin
                    r_mem[g] <= r_mem[g-1];
                end
            end
        end
    end

    // Clamp the read address at 0 while empty so it never points outside the storage.
    assign w_raddr    = (r_cnt == '0) ? '0 : ADDR_WIDTH'(r_cnt - 1'b1);
    assign if_dout    = r_mem[w_raddr];
    assign if_empty_n = r_empty_n;
    assign if_full_n  = r_full_n;

endmodule

// File: tb/tb_start_srl_fifo.sv
// Self-checking bench for start_srl_fifo: directed boundary scenarios plus a randomized run
// checked against a queue-based FIFO model.
module tb_start_srl_fifo;

    localparam int DW    = 8;
    localparam int AW    = 1;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_write_ce;
    logic          if_write;
    logic [DW-1:0] if_din;
    logic          if_full_n;
    logic          if_read_ce;
    logic          if_read;
    logic [DW-1:0] if_dout;
    logic          if_empty_n;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [DW-1:0] model_q [$];

    start_srl_fifo #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .if_write_ce(if_write_ce),
        .if_write   (if_write),
        .if_din     (if_din),
        .if_full_n  (if_full_n),
        .if_read_ce (if_read_ce),
        .if_read    (if_read),
        .if_dout    (if_dout),
        .if_empty_n (if_empty_n)
    );

    always #5 clk = ~clk;

    task automatic set_in(input logic wce, input logic w, input logic [DW-1:0] d,
                          input logic rce, input logic r);
        if_write_ce = wce;
        if_write    = w;
        if_din      = d;
        if_read_ce  = rce;
        if_read     = r;
    endtask

    // Advance one clock: the model applies the FIFO rules to the current inputs,
    // then outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        bit do_push;
        bit do_pop;
        do_push = if_write_ce && if_write && (model_q.size() < DEPTH);
        do_pop  = if_read_ce  && if_read  && (model_q.size() > 0);
        if (do_pop)  void'(model_q.pop_front());
        if (do_push) model_q.push_back(if_din);
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d);
        set_in(1'b1, 1'b1, d, 1'b1, 1'b0);
        tick();
        set_in(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic pop();
        set_in(1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
        tick();
        set_in(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic push_pop(input logic [DW-1:0] d);
        set_in(1'b1, 1'b1, d, 1'b1, 1'b1);
        tick();
        set_in(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    // Called 1 ns after an edge; asserts reset mid-cycle and releases it before the next edge.
    task automatic pulse_reset();
        #3;
        reset = 1'b1;
        model_q.delete();
        #2;
        reset = 1'b0;
        #4;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        set_in(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        reset = 1'b1;
        #12;
        n_cmp++;
        if (if_empty_n !== 1'b0 || if_full_n !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_hold: empty_n=%b full_n=%b, want empty_n=0 full_n=1", if_empty_n, if_full_n);
        end
        @(negedge clk);
        reset = 1'b0;
        model_q.delete();
        @(posedge clk);
        #1;
        push(8'h11);
        push(8'h22);
        // Reset asserted between edges must clear the flags without waiting for a clock.
        #2;
        reset = 1'b1;
        model_q.delete();
        #1;
        n_cmp++;
        if (if_empty_n !== 1'b0 || if_full_n !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_async: empty_n=%b full_n=%b, want empty_n=0 full_n=1", if_empty_n, if_full_n);
        end
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fill_drain();
        push(8'h11);
        n_cmp++;
        if (if_empty_n !== 1'b1 || if_full_n !== 1'b1 || if_dout !== 8'h11) begin
            n_fail++;
            $display("FAIL fwft_first: empty_n=%b full_n=%b dout=%h, want 1 1 11", if_empty_n, if_full_n, if_dout);
        end
        push(8'h22);
        n_cmp++;
        if (if_full_n !== 1'b0 || if_empty_n !== 1'b1 || if_dout !== 8'h11) begin
            n_fail++;
            $display("FAIL fill_full: full_n=%b empty_n=%b dout=%h, want 0 1 11", if_full_n, if_empty_n, if_dout);
        end
        pop();
        n_cmp++;
        if (if_dout !== 8'h22 || if_full_n !== 1'b1 || if_empty_n !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_one: dout=%h full_n=%b empty_n=%b, want 22 1 1", if_dout, if_full_n, if_empty_n);
        end
        pop();
        n_cmp++;
        if (if_empty_n !== 1'b0 || if_full_n !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_empty: empty_n=%b full_n=%b, want 0 1", if_empty_n, if_full_n);
        end
    endtask

    task automatic test_overflow_underflow();
        push(8'h11);
        push(8'h22);
        push(8'h33);
        n_cmp++;
        if (if_full_n !== 1'b0 || if_dout !== 8'h11) begin
            n_fail++;
            $display("FAIL overflow_hold: full_n=%b dout=%h, want 0 11", if_full_n, if_dout);
        end
        pop();
        n_cmp++;
        if (if_dout !== 8'h22 || if_empty_n !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_second: dout=%h empty_n=%b, want 22 1", if_dout, if_empty_n);
        end
        pop();
        pop();
        n_cmp++;
        if (if_empty_n !== 1'b0 || if_full_n !== 1'b1) begin
            n_fail++;
            $display("FAIL underflow: empty_n=%b full_n=%b, want 0 1", if_empty_n, if_full_n);
        end
        // A pop while empty must not wrap the count: one push should make it exactly 1.
        push(8'h3c);
        n_cmp++;
        if (if_empty_n !== 1'b1 || if_full_n !== 1'b1 || if_dout !== 8'h3c) begin
            n_fail++;
            $display("FAIL underflow_recover: empty_n=%b full_n=%b dout=%h, want 1 1 3c", if_empty_n, if_full_n, if_dout);
        end
        pop();
    endtask

    task automatic test_simultaneous();
        push(8'h11);
        push_pop(8'h44);
        n_cmp++;
        if (if_empty_n !== 1'b1 || if_full_n !== 1'b1 || if_dout !== 8'h44) begin
            n_fail++;
            $display("FAIL pushpop_mid: empty_n=%b full_n=%b dout=%h, want 1 1 44", if_empty_n, if_full_n, if_dout);
        end
        push(8'h55);
        push_pop(8'h66);
        n_cmp++;
        if (if_empty_n !== 1'b1 || if_full_n !== 1'b1 || if_dout !== 8'h55) begin
            n_fail++;
            $display("FAIL pushpop_full: empty_n=%b full_n=%b dout=%h, want 1 1 55", if_empty_n, if_full_n, if_dout);
        end
        pop();
        n_cmp++;
        if (if_empty_n !== 1'b0) begin
            n_fail++;
            $display("FAIL pushpop_full_lost: empty_n=%b, want 0", if_empty_n);
        end
        // Empty boundary: push and pop together accepts only the push.
        push_pop(8'h77);
        n_cmp++;
        if (if_empty_n !== 1'b1 || if_full_n !== 1'b1 || if_dout !== 8'h77) begin
            n_fail++;
            $display("FAIL pushpop_empty: empty_n=%b full_n=%b dout=%h, want 1 1 77", if_empty_n, if_full_n, if_dout);
        end
        pop();
    endtask

    task automatic test_clock_enables();
        push(8'h11);
        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, 1'b1, 8'h99, 1'b1, 1'b0);
            tick();
            n_cmp++;
            if (if_empty_n !== 1'b1 || if_full_n !== 1'b1 || if_dout !== 8'h11) begin
                n_fail++;
                $display("FAIL write_ce_off[%0d]: empty_n=%b full_n=%b dout=%h, want 1 1 11",
                         i, if_empty_n, if_full_n, if_dout);
            end
        end
        set_in(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        tick();
        tick();
        n_cmp++;
        if (if_empty_n !== 1'b1 || if_dout !== 8'h11) begin
            n_fail++;
            $display("FAIL read_ce_off: empty_n=%b dout=%h, want 1 11", if_empty_n, if_dout);
        end
        pop();
    endtask

    task automatic test_reset_mid_op();
        push(8'h11);
        push(8'h22);
        pulse_reset();
        n_cmp++;
        if (if_empty_n !== 1'b0 || if_full_n !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_flags: empty_n=%b full_n=%b, want 0 1", if_empty_n, if_full_n);
        end
        push(8'h55);
        n_cmp++;
        if (if_empty_n !== 1'b1 || if_full_n !== 1'b1 || if_dout !== 8'h55) begin
            n_fail++;
            $display("FAIL reset_mid_push: empty_n=%b full_n=%b dout=%h, want 1 1 55", if_empty_n, if_full_n, if_dout);
        end
        pop();
    endtask

    task automatic test_random();
        logic exp_empty_n;
        logic exp_full_n;
        pulse_reset();
        for (int i = 0; i < 500; i++) begin
            set_in(1'($urandom_range(0, 3) != 0), 1'($urandom), 8'($urandom),
                   1'($urandom_range(0, 3) != 0), 1'($urandom));
            tick();
            exp_empty_n = (model_q.size() != 0);
            exp_full_n  = (model_q.size() != DEPTH);
            n_cmp++;
            if (if_empty_n !== exp_empty_n || if_full_n !== exp_full_n ||
                (exp_empty_n && if_dout !== model_q[0])) begin
                n_fail++;
                $display("FAIL random[%0d]: empty_n=%b full_n=%b dout=%h, want %b %b %h",
                         i, if_empty_n, if_full_n, if_dout, exp_empty_n, exp_full_n,
                         exp_empty_n ? model_q[0] : if_dout);
            end
        end
        set_in(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow_underflow();
        test_simultaneous();
        test_clock_enables();
        test_reset_mid_op();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/start_srl_fifo.md
START_SRL_FIFO -- requirements
Module: start_srl_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 1: payload width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 1: storage index width, with 2^ADDR_WIDTH >= DEPTH.
REQ-003 SHALL have parameter DEPTH, default 2: number of entries, DEPTH >= 1.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port if_write_ce, input, 1 bit: write-side clock enable.
REQ-007 SHALL have port if_write, input, 1 bit: push request.
REQ-008 SHALL have port if_din, input, DATA_WIDTH bits: push data.
REQ-009 SHALL have port if_full_n, output, 1 bit: high while the FIFO can accept a push.
REQ-010 SHALL have port if_read_ce, input, 1 bit: read-side clock enable.
REQ-011 SHALL have port if_read, input, 1 bit: pop request.
REQ-012 SHALL have port if_dout, output, DATA_WIDTH bits: oldest stored entry.
REQ-013 SHALL have port if_empty_n, output, 1 bit: high while if_dout holds valid data.

Function
REQ-014 SHALL store data in a DEPTH-entry shift register: on an accepted push, entry[i+1] <= entry[i] for all i < DEPTH-1, and entry[0] <= if_din.
REQ-015 SHALL hold an occupancy counter cnt, range 0..DEPTH, of width ADDR_WIDTH+1.
REQ-016 SHALL accept a push when if_write_ce=1, if_write=1 and if_full_n=1; otherwise the push is ignored and storage and cnt are unchanged.
REQ-017 SHALL accept a pop when if_read_ce=1, if_read=1 and if_empty_n=1; otherwise the pop is ignored.
REQ-018 SHALL drive if_dout combinationally as entry[cnt-1] when cnt > 0, and as entry[0] when cnt = 0, so the read address never goes out of range.
REQ-019 SHALL update cnt as follows: push only -> cnt+1; pop only -> cnt-1; push and pop together -> cnt unchanged, with the data shifting so that if_dout shows the next-oldest entry.
REQ-020 SHALL update if_empty_n and if_full_n as registered flags from the next value of cnt: if_empty_n = (cnt_next != 0) and if_full_n = (cnt_next != DEPTH).
REQ-021 SHALL present pushed data with first-word fall-through: data pushed into an empty FIFO at edge k appears on if_dout, with if_empty_n=1, immediately after edge k.
REQ-022 SHALL honour the full boundary: when full, a simultaneous push and pop accepts only the pop, because if_full_n=0 gates the push; cnt becomes DEPTH-1.
REQ-023 SHALL honour the empty boundary: when empty, a simultaneous push and pop accepts only the push; cnt becomes 1.
REQ-024 SHALL ignore if_write and if_read entirely when their respective ce is 0.

Reset
REQ-025 SHALL, while reset=1 and regardless of clk, force cnt=0, if_empty_n=0 and if_full_n=1.
REQ-026 SHALL not reset storage contents; if_dout is don't-care while if_empty_n=0.
REQ-027 SHALL discard all stored entries when reset is asserted mid-operation; the first push after reset release is the first entry read out.

Verification (DATA_WIDTH=8, ADDR_WIDTH=1, DEPTH=2, ce=1 unless stated)
REQ-028 SHALL verify reset: assert reset between clock edges -> cnt=0, if_empty_n=0 and if_full_n=1 without waiting for a clock edge.
REQ-029 SHALL verify fill/drain: push 0x11 then 0x22 -> if_full_n=0 and if_dout=0x11; pop -> if_dout=0x22; pop -> if_empty_n=0 and if_full_n=1.
REQ-030 SHALL verify overflow and underflow: push 0x33 when full -> ignored, and later pops return 0x11 then 0x22; pop when empty -> cnt stays 0.
REQ-031 SHALL verify simultaneous push and pop: with 0x11 held, push 0x44 and pop together -> cnt=1 and if_dout=0x44; when full, push and pop together -> cnt=1 and the pushed data is lost.
REQ-032 SHALL verify clock enables: if_write_ce=0 with if_write=1 for 3 cycles -> no change; if_read_ce=0 with if_read=1 -> no pop.
REQ-033 SHALL verify reset mid-operation: with 2 entries held, pulse reset, then push 0x55 -> if_dout=0x55 and cnt=1.
